psum_accum_drain: RTL
=====================

Name: psum_accum_drain

Overview:
- Sits at the output end of the corelet and reads its output FIFO.
- For every nij, it accumulates per-column partial sums across all kij passes in an internal register buffer.
- After the final kij pass it streams the finished outputs to the next stage over a valid/ready handshake, with optional ReLU.
- Together with the weight/activation sequencer it replaces the bench-side readout.

Parameters:
- col, 8, number of output columns per word
- psum_bw, 16, bit width of each partial sum (two's complement)
- nij_len, 36, output pixels per kij pass
- kij_len, 9, kernel positions accumulated per output

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately
- start  input  1  one-cycle pulse that begins a new layer; honoured only in IDLE
- relu_en  input  1  sampled at start; 1 applies ReLU on drain
- in_valid  input  1  corelet OFIFO not empty; in_psum holds the head word (show-ahead)
- in_psum  input  col*psum_bw  head word; column c is bits [c*psum_bw +: psum_bw]
- rd  output  1  pop request to the corelet OFIFO
- out_valid  output  1  out_data holds a finished word
- out_ready  input  1  downstream accepts out_data
- out_data  output  col*psum_bw  finished word, same column packing as in_psum
- out_nij  output  $clog2(nij_len)  nij index of out_data
- busy  output  1  high in ACCUM or DRAIN
- done  output  1  one-cycle pulse after the last word is accepted

Behaviour:
- Reset values while reset=0: state=IDLE; rd=0; out_valid=0; out_data=0; out_nij=0; busy=0; done=0; nij_cnt=0; kij_cnt=0; all buffer entries 0; relu latch 0.
- FSM IDLE -> ACCUM: on start=1. Same edge clears every buffer entry and both counters, and latches relu_en.
- start outside IDLE is ignored.
- ACCUM:
  - rd = in_valid, combinationally. No pop in any other state.
  - Each cycle with rd=1: buf[nij_cnt][c] <= buf[nij_cnt][c] + in_psum[c] for every c, in the same edge.
  - Addition is signed and psum_bw wide, wrapping modulo 2^psum_bw, no saturation.
  - nij_cnt increments per pop. When it reaches nij_len-1 it wraps to 0 and kij_cnt increments.
  - A pop at nij_cnt=nij_len-1 with kij_cnt=kij_len-1 moves to DRAIN and sets the drain index to 0.
  - Cycles with in_valid=0 are stalls: no state change.
- DRAIN:
  - out_valid=1 from the first DRAIN cycle.
  - out_data = buf[idx]. With the relu latch set, each negative column (MSB=1) is output as 0.
  - out_nij = idx.
  - out_data and out_nij are registered and held stable while out_valid=1 and out_ready=0.
  - On out_valid & out_ready: idx increments and the next word appears the following cycle.
  - Throughput is 1 word/cycle under continuous ready.
  - Acceptance of idx=nij_len-1 -> IDLE, with out_valid=0 and done=1 for exactly one cycle.
- Data popped is never lost or double-counted. in_valid high in IDLE/DRAIN is left in the FIFO.
- A reset assertion mid-ACCUM or mid-DRAIN aborts immediately to the reset values. A new start is required afterwards.
- Total pops per layer = nij_len*kij_len. Total output words per layer = nij_len, in ascending nij order.

Test Plan:
- Every pop has all columns = 0x0001, in_valid held high, out_ready=1 -> 324 pops in 324 cycles; 36 words out; each column = 0x0009; out_nij counts 0..35; done pulses once.
- Column 0 = 0xFFFE (-2) on every pop, other columns 0x0003 -> relu_en=0: col0=0xFFEE, others=0x001B. relu_en=1: col0=0x0000, others=0x001B.
- Wrap: nij 0 col 0 gets 0x7FFF in pass 0 and 0x0001 in pass 1, 0 elsewhere -> 0x8000 out (relu_en=0). relu_en=1 -> 0x0000.
- Random in_valid gaps (≈50%) and random out_ready -> sums match a golden model. rd never high when in_valid=0. out_data stable while stalled.
- start pulsed again during ACCUM -> ignored, result unchanged. start with in_valid=1 in IDLE -> no pop on that cycle.
- reset=0 for one cycle after 100 pops -> all outputs return to reset values at once, rd=0. A fresh start then yields clean results (all 0x0009 for the all-ones stream).

Source files
------------

// File: rtl/psum_accum_drain.sv
// Output-side partial-sum accumulator: sums every kij pass per nij and column,
// then drains the finished words over valid/ready with optional ReLU.
module psum_accum_drain #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int nij_len = 36,
    parameter int kij_len = 9
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        relu_en,
    input  logic                        in_valid,
    input  logic [col*psum_bw-1:0]      in_psum,
    output logic                        rd,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [col*psum_bw-1:0]      out_data,
    output logic [$clog2(nij_len)-1:0]  out_nij,
    output logic                        busy,
    output logic                        done
);
    localparam int word_w = col * psum_bw;
    localparam int nij_w  = $clog2(nij_len);
    localparam int kij_w  = (kij_len > 1) ? $clog2(kij_len) : 1;
    localparam logic [nij_w-1:0] nij_last = nij_w'(nij_len - 1);
    localparam logic [kij_w-1:0] kij_last = kij_w'(kij_len - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

    state_t             state;
    logic [nij_w-1:0]   nij_cnt;
    logic [nij_w-1:0]   nij_next;
    logic [kij_w-1:0]   kij_cnt;
    logic               relu_q;
    logic               clear;
    logic               pop;
    logic [word_w-1:0]  acc_buf [nij_len];

    function automatic logic [word_w-1:0] add_word(input logic [word_w-1:0] a,
                                                   input logic [word_w-1:0] b);
        logic [word_w-1:0] r;
        r = '0;
        for (int c = 0; c < col; c++)
            r[c*psum_bw +: psum_bw] = a[c*psum_bw +: psum_bw] + b[c*psum_bw +: psum_bw];
        return r;
    endfunction

    function automatic logic [word_w-1:0] relu_word(input logic [word_w-1:0] w,
                                                    input logic             en);
        logic [word_w-1:0] r;
        r = w;
        for (int c = 0; c < col; c++)
            if (en && w[c*psum_bw + psum_bw - 1])
                r[c*psum_bw +: psum_bw] = '0;
        return r;
    endfunction

    // NOTE: rd is a plain combinational echo of in_valid while accumulating, so a
    // show-ahead word is consumed on the same edge it is summed and never twice.
    assign pop      = (state == ACCUM) && in_valid;
    assign rd       = pop;
    assign clear    = (state == IDLE) && start;
    assign busy     = (state != IDLE);
    assign nij_next = out_nij + 1'b1;

    for (genvar n = 0; n < nij_len; n++) begin : g_entry
        logic [word_w-1:0] entry;

        // NOTE: the buffer is reset as well as cleared on start, so an aborted
        // layer never leaks partial sums into the next one.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset)
                entry <= '0;
            else if (clear)
                entry <= '0;
            else if (pop && nij_cnt == nij_w'(n))
                entry <= add_word(entry, in_psum);
        end

        assign acc_buf[n] = entry;
    end

    // NOTE: all state below uses non-blocking assignments so every register sees
    // the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            nij_cnt   <= '0;
            kij_cnt   <= '0;
            relu_q    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_nij   <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= ACCUM;
                        nij_cnt <= '0;
                        kij_cnt <= '0;
                        relu_q  <= relu_en;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        if (nij_cnt == nij_last) begin
                            nij_cnt <= '0;
                            if (kij_cnt == kij_last) begin
                                // Entry 0 was finished on an earlier pass.
                                state     <= DRAIN;
                                kij_cnt   <= '0;
                                out_valid <= 1'b1;
                                out_nij   <= '0;
                                out_data  <= relu_word(acc_buf[0], relu_q);
                            end else begin
                                kij_cnt <= kij_cnt + 1'b1;
                            end
                        end else begin
                            nij_cnt <= nij_cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (out_nij == nij_last) begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            out_nij  <= nij_next;
                            out_data <= relu_word(acc_buf[nij_next], relu_q);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
